lmsm_sequencer: RTL and testbench
=================================

// Module: lmsm_sequencer
// PURPOSE
// Expands one LM/SM instruction from the decode stage into per-register micro-ops.
// Consumes the decoder's LMstart code and the IW register mask.
// Emits one register index, memory address and direction per handshake to the register-read/execute stage.
// Stalls IF/ID while the expansion is in progress.
// PARAMETERS
// DATA_W  16  address/data width
// MASK_W  8   register-mask width (IW[7:0]); bit i selects Ri
// REG_AW  3   register index width
// PORTS
// clk         in   1       rising-edge clock
// reset       in   1       asynchronous, active-high reset
// id_valid    in   1       IW in decode is valid this cycle
// LMstart     in   2       decoder code: 0x=none, 10=SM (reg->mem), 11=LM (mem->reg)
// IW          in   16      instruction word; mask = IW[7:0]
// base_addr   in   DATA_W  RA value read for this instruction
// ex_ready    in   1       downstream accepts current micro-op
// flush       in   1       synchronous abort from a later-stage redirect
// seq_valid   out  1       micro-op valid
// seq_reg     out  REG_AW  register to load/store
// seq_addr    out  DATA_W  memory address for this micro-op
// seq_load    out  1       1=LM (W_reg path), 0=SM (W_mem path); meaningful only when seq_valid=1
// stall       out  1       hold PC and IF/ID register
// busy        out  1       FSM not IDLE
// done        out  1       one-cycle pulse: sequence complete
// BEHAVIOUR
// - Reset (async, any state): FSM=IDLE, mask/base/count regs=0.
//   All outputs 0: seq_valid, seq_reg, seq_addr, seq_load, stall, busy, done.
// - States: IDLE, RUN, ZERO.
// - IDLE -> start when id_valid & LMstart[1] & ~flush.
//   Latch mask=IW[7:0], base=base_addr, dir=LMstart[0], count=0.
//   Goes to RUN if mask!=0; goes to ZERO if mask==0.
// - stall is combinational: (IDLE & start) | RUN | ZERO. It is asserted in the start cycle.
// - RUN: seq_valid=1.
//   seq_reg = index of lowest set bit of the mask register (ascending order, R0 first).
//   seq_addr = base + count, computed modulo 2^DATA_W (0xFFFF+1 wraps to 0x0000).
//   seq_load=dir.
// - Handshake: a micro-op transfers when seq_valid & ex_ready.
//   On transfer: clear that mask bit, count+=1.
//   When ex_ready=0, seq_reg, seq_addr and seq_load hold stable.
// - done = RUN & seq_valid & ex_ready & (mask is one-hot), combinational, i.e. asserted in the final transfer cycle.
//   The next state is IDLE, so stall drops in the following cycle.
// - ZERO: lasts one cycle with done=1 and seq_valid=0, then goes to IDLE.
// - Latency: start in cycle T -> first seq_valid in T+1.
//   With an N-bit mask and ex_ready always high, there are N valid cycles, T+1..T+N, and done in T+N.
// - flush has priority over everything except reset.
//   In any state -> IDLE next cycle, mask cleared, no done.
//   A transfer in the flush cycle still counts downstream; the sequencer drops the remainder.
// - id_valid/LMstart are ignored while busy; no queuing.
// - LMstart=0x with id_valid -> no action, stall=0.
// - count width = clog2(MASK_W)+1; the maximum is MASK_W and it never overflows.
// TESTING
// - LM: IW[7:0]=0xA5, base=0x0010, ex_ready=1 -> transfers (R0,0x10),(R2,0x11),(R5,0x12),(R7,0x13).
//   seq_load=1 throughout; done in the 4th valid cycle; stall high 5 cycles.
// - SM wrap: mask=0x03, base=0xFFFF -> (R0,0xFFFF),(R1,0x0000); seq_load=0; done on the 2nd transfer.
// - Backpressure: mask=0x06, ex_ready low 3 cycles on the first op -> seq_reg=1 and seq_addr=base held for 3 cycles.
//   Then R1 then R2 transfer; exactly 2 transfers total.
// - Zero mask: LM with mask=0x00 -> no seq_valid, done pulse at T+1, stall high T..T+1, busy low at T+2.
// - Reset/flush mid-op: mask=0xFF, assert flush after the 3rd transfer -> IDLE next cycle, no done.
//   Repeat the run with async reset between edges -> all outputs 0 immediately; next LM starts cleanly from R0.
// - Ignore while busy: new LM on IW during RUN -> the original sequence completes unchanged; the new IW is not started.

Source files
------------

// File: rtl/lmsm_sequencer.sv
// lmsm_sequencer: expands one LM/SM instruction into per-register load/store micro-ops
module lmsm_sequencer #(
    parameter int DATA_W = 16,
    parameter int MASK_W = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [1:0]        LMstart,
    input  logic [15:0]       IW,
    input  logic [DATA_W-1:0] base_addr,
    input  logic              ex_ready,
    input  logic              flush,
    output logic              seq_valid,
    output logic [REG_AW-1:0] seq_reg,
    output logic [DATA_W-1:0] seq_addr,
    output logic              seq_load,
    output logic              stall,
    output logic              busy,
    output logic              done
);
    localparam int CNT_W = $clog2(MASK_W) + 1;
    typedef enum logic [1:0] {IDLE, RUN, ZERO} state_t;
    state_t            state;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] base;
    logic [CNT_W-1:0]  count;
    logic              dir;
    logic              start;
    logic              xfer;
    logic              last;
    logic [MASK_W-1:0] rest;
    logic [REG_AW-1:0] low_idx;
    logic              unused_iw;
    assign unused_iw = ^IW[15:MASK_W];
    assign start = (state == IDLE) & id_valid & LMstart[1] & ~flush;
    // rest = mask with its lowest set bit cleared; empty rest means this is the final op
    assign rest = mask & (mask - MASK_W'(1));
    assign last = rest == '0;
    assign xfer = seq_valid & ex_ready;
    always_comb begin
        low_idx = '0;
        for (int i = MASK_W - 1; i >= 0; i--)
            if (mask[i]) low_idx = REG_AW'(i);
    end
    assign seq_valid = state == RUN;
    assign seq_reg   = seq_valid ? low_idx : '0;
    assign seq_addr  = seq_valid ? base + DATA_W'(count) : '0;
    assign seq_load  = seq_valid & dir;
    assign busy      = state != IDLE;
    assign stall     = start | busy;
    assign done      = ~flush & ((xfer & last) | (state == ZERO));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mask  <= '0;
            base  <= '0;
            count <= '0;
            dir   <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            mask  <= '0;
        end else if (start) begin
            mask  <= IW[MASK_W-1:0];
            base  <= base_addr;
            dir   <= LMstart[0];
            count <= '0;
            state <= (IW[MASK_W-1:0] != '0) ? RUN : ZERO;
        end else if (state == ZERO) begin
            state <= IDLE;
        end else if (xfer) begin
            mask  <= rest;
            count <= count + CNT_W'(1);
            if (last) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_lmsm_sequencer.sv
// tb_lmsm_sequencer: directed vectors with hand-computed expectations for lmsm_sequencer
module tb_lmsm_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [1:0]  LMstart;
    logic [15:0] IW;
    logic [15:0] base_addr;
    logic        ex_ready;
    logic        flush;
    logic        seq_valid;
    logic [2:0]  seq_reg;
    logic [15:0] seq_addr;
    logic        seq_load;
    logic        stall;
    logic        busy;
    logic        done;
    int vectors = 0;
    int miscompares = 0;
    lmsm_sequencer dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .LMstart(LMstart), .IW(IW),
        .base_addr(base_addr), .ex_ready(ex_ready), .flush(flush), .seq_valid(seq_valid),
        .seq_reg(seq_reg), .seq_addr(seq_addr), .seq_load(seq_load), .stall(stall),
        .busy(busy), .done(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // settle 1 time unit after the inputs were driven, then compare every output
    task automatic chk_out(input string tag, input logic v, input logic [2:0] r, input logic [15:0] a,
                           input logic l, input logic s, input logic b, input logic d);
        #1;
        chk({tag, ".valid"}, 16'(seq_valid), 16'(v));
        chk({tag, ".reg"},   16'(seq_reg),   16'(r));
        chk({tag, ".addr"},  seq_addr,       a);
        chk({tag, ".load"},  16'(seq_load),  16'(l));
        chk({tag, ".stall"}, 16'(stall),     16'(s));
        chk({tag, ".busy"},  16'(busy),      16'(b));
        chk({tag, ".done"},  16'(done),      16'(d));
    endtask
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [1:0] code, input logic [15:0] iw, input logic [15:0] base);
        id_valid = 1'b1; LMstart = code; IW = iw; base_addr = base;
    endtask
    initial begin
        reset = 1'b1; id_valid = 1'b0; LMstart = 2'b00; IW = '0; base_addr = '0;
        ex_ready = 1'b1; flush = 1'b0;
        chk_out("reset", 0, 0, 16'h0000, 0, 0, 0, 0);
        nxt(); reset = 1'b0;
        chk_out("idle", 0, 0, 16'h0000, 0, 0, 0, 0);
        // LM 0xA5 from 0x0010
        nxt(); issue(2'b11, 16'h00A5, 16'h0010);
        chk_out("lm.t0", 0, 0, 16'h0000, 0, 1, 0, 0);
        nxt(); id_valid = 1'b0;
        chk_out("lm.r0", 1, 0, 16'h0010, 1, 1, 1, 0);
        nxt(); chk_out("lm.r2", 1, 2, 16'h0011, 1, 1, 1, 0);
        nxt(); chk_out("lm.r5", 1, 5, 16'h0012, 1, 1, 1, 0);
        nxt(); chk_out("lm.r7", 1, 7, 16'h0013, 1, 1, 1, 1);
        nxt(); chk_out("lm.end", 0, 0, 16'h0000, 0, 0, 0, 0);
        // SM wraps past 0xFFFF
        nxt(); issue(2'b10, 16'h0003, 16'hFFFF);
        chk_out("sm.t0", 0, 0, 16'h0000, 0, 1, 0, 0);
        nxt(); id_valid = 1'b0;
        chk_out("sm.r0", 1, 0, 16'hFFFF, 0, 1, 1, 0);
        nxt(); chk_out("sm.r1", 1, 1, 16'h0000, 0, 1, 1, 1);
        nxt(); chk_out("sm.end", 0, 0, 16'h0000, 0, 0, 0, 0);
        // backpressure holds the first op for 3 cycles
        nxt(); issue(2'b11, 16'h0006, 16'h0100); ex_ready = 1'b0;
        chk_out("bp.t0", 0, 0, 16'h0000, 0, 1, 0, 0);
        nxt(); id_valid = 1'b0;
        chk_out("bp.h1", 1, 1, 16'h0100, 1, 1, 1, 0);
        nxt(); chk_out("bp.h2", 1, 1, 16'h0100, 1, 1, 1, 0);
        nxt(); chk_out("bp.h3", 1, 1, 16'h0100, 1, 1, 1, 0);
        nxt(); ex_ready = 1'b1;
        chk_out("bp.r1", 1, 1, 16'h0100, 1, 1, 1, 0);
        nxt(); chk_out("bp.r2", 1, 2, 16'h0101, 1, 1, 1, 1);
        nxt(); chk_out("bp.end", 0, 0, 16'h0000, 0, 0, 0, 0);
        // zero mask
        nxt(); issue(2'b11, 16'h0000, 16'h0200);
        chk_out("zero.t0", 0, 0, 16'h0000, 0, 1, 0, 0);
        nxt(); id_valid = 1'b0;
        chk_out("zero.t1", 0, 0, 16'h0000, 0, 1, 1, 1);
        nxt(); chk_out("zero.t2", 0, 0, 16'h0000, 0, 0, 0, 0);
        // flush after third transfer
        nxt(); issue(2'b11, 16'h00FF, 16'h0020);
        chk_out("fl.t0", 0, 0, 16'h0000, 0, 1, 0, 0);
        nxt(); id_valid = 1'b0;
        chk_out("fl.r0", 1, 0, 16'h0020, 1, 1, 1, 0);
        nxt(); chk_out("fl.r1", 1, 1, 16'h0021, 1, 1, 1, 0);
        nxt(); chk_out("fl.r2", 1, 2, 16'h0022, 1, 1, 1, 0);
        nxt(); flush = 1'b1;
        chk_out("fl.r3", 1, 3, 16'h0023, 1, 1, 1, 0);
        nxt(); flush = 1'b0;
        chk_out("fl.end", 0, 0, 16'h0000, 0, 0, 0, 0);
        // same run, async reset between edges
        nxt(); issue(2'b11, 16'h00FF, 16'h0020);
        chk_out("ar.t0", 0, 0, 16'h0000, 0, 1, 0, 0);
        nxt(); id_valid = 1'b0;
        chk_out("ar.r0", 1, 0, 16'h0020, 1, 1, 1, 0);
        nxt(); chk_out("ar.r1", 1, 1, 16'h0021, 1, 1, 1, 0);
        reset = 1'b1;
        chk_out("ar.rst", 0, 0, 16'h0000, 0, 0, 0, 0);
        nxt(); reset = 1'b0;
        chk_out("ar.idle", 0, 0, 16'h0000, 0, 0, 0, 0);
        nxt(); issue(2'b11, 16'h0081, 16'h0040);
        chk_out("ar2.t0", 0, 0, 16'h0000, 0, 1, 0, 0);
        nxt(); id_valid = 1'b0;
        chk_out("ar2.r0", 1, 0, 16'h0040, 1, 1, 1, 0);
        nxt(); chk_out("ar2.r7", 1, 7, 16'h0041, 1, 1, 1, 1);
        nxt(); chk_out("ar2.end", 0, 0, 16'h0000, 0, 0, 0, 0);
        // new LM presented while busy is ignored
        nxt(); issue(2'b10, 16'h000C, 16'h0050);
        chk_out("ib.t0", 0, 0, 16'h0000, 0, 1, 0, 0);
        nxt(); issue(2'b11, 16'h00F0, 16'h0099);
        chk_out("ib.r2", 1, 2, 16'h0050, 0, 1, 1, 0);
        nxt(); id_valid = 1'b0;
        chk_out("ib.r3", 1, 3, 16'h0051, 0, 1, 1, 1);
        nxt(); chk_out("ib.end", 0, 0, 16'h0000, 0, 0, 0, 0);
        // non-LM/SM code and a flushed start both do nothing
        nxt(); issue(2'b01, 16'h00FF, 16'h0070);
        chk_out("none", 0, 0, 16'h0000, 0, 0, 0, 0);
        nxt(); LMstart = 2'b11; flush = 1'b1;
        chk_out("flstart", 0, 0, 16'h0000, 0, 0, 0, 0);
        nxt(); id_valid = 1'b0; flush = 1'b0;
        chk_out("final", 0, 0, 16'h0000, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
